maxnet_weight_store: RTL

//  Parametrised storage for a MaxNet layer: N-entry input vector X (writable) and NxN

---
 rtl/maxnet_weight_store.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/maxnet_weight_store.sv
// MaxNet weight/input store: holds the X vector and the SELF/EPS weight registers and
// streams weight rows (or the whole matrix) paired with X[col] over a valid/ready channel.
`timescale 1ns/1ps

module maxnet_weight_store #(
    parameter int             N         = 4,
    parameter int             W         = 5,
    parameter logic [W-1:0]   SELF_INIT = 5'b01000,
    parameter logic [W-1:0]   EPS_INIT  = 5'b11110,
    localparam int            AW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          x_wr_en,
    input  logic [AW-1:0] x_wr_addr,
    input  logic [W-1:0]  x_wr_data,
    input  logic          cfg_wr_en,
    input  logic          cfg_sel,
    input  logic [W-1:0]  cfg_wr_data,
    input  logic          rd_start,
    input  logic          rd_mode,
    input  logic [AW-1:0] rd_row,
    output logic          busy,
    output logic          rd_err,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_w,
    output logic [W-1:0]  out_x,
    output logic [AW-1:0] out_row,
    output logic [AW-1:0] out_col,
    output logic          out_last
);

    // state  | meaning
    // IDLE   | no stream, waiting for an acceptable rd_start
    // STREAM | beats being presented; left when the out_last beat is accepted
    typedef enum logic {S_IDLE, S_STREAM} state_t;

    localparam logic [AW:0]   NUM  = (AW+1)'(N);
    localparam logic [AW-1:0] LAST = AW'(N-1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_t        state, nxt_state;
    logic [W-1:0]  x_mem [N];
    logic [W-1:0]  self_reg, eps_reg, self_sh, eps_sh;
    logic          mode_q;

    logic          row_oob, start_ok, start_bad, accept;
    logic          ld, ld_cfg, ld_mode;
    logic [AW-1:0] ld_row, ld_col;
    logic          nxt_valid, nxt_last, nxt_err;
    logic [W-1:0]  nxt_w, nxt_x;
    logic [AW-1:0] nxt_row, nxt_col;

    assign busy      = (state == S_STREAM);
    assign accept    = out_valid & out_ready;
    assign row_oob   = !rd_mode && ({1'b0, rd_row} >= NUM);
    assign start_ok  = (state == S_IDLE) && rd_start && !row_oob;
    assign start_bad = (state == S_IDLE) && rd_start && row_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        ld        = 1'b0;
        ld_cfg    = 1'b0;
        ld_mode   = mode_q;
        ld_row    = out_row;
        ld_col    = out_col;
        nxt_valid = out_valid;
        nxt_last  = out_last;
        nxt_w     = out_w;
        nxt_x     = out_x;
        nxt_row   = out_row;
        nxt_col   = out_col;
        nxt_err   = start_bad;

        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    nxt_state = S_STREAM;
                    ld        = 1'b1;
                    ld_cfg    = 1'b1;
                    ld_mode   = rd_mode;
                    ld_row    = rd_mode ? '0 : rd_row;
                    ld_col    = '0;
                end
            end
            S_STREAM: begin
                if (accept) begin
                    if (out_last) begin
                        nxt_state = S_IDLE;
                        nxt_valid = 1'b0;
                        nxt_last  = 1'b0;
                    end else begin
                        ld = 1'b1;
                        if (out_col == LAST) begin
                            ld_col = '0;
                            ld_row = out_row + ONE;
                        end else begin
                            ld_col = out_col + ONE;
                        end
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase

        // First beat reads the live registers, which are being snapshotted on the same edge.
        if (ld) begin
            nxt_valid = 1'b1;
            nxt_row   = ld_row;
            nxt_col   = ld_col;
            nxt_x     = x_mem[ld_col];
            if (ld_row == ld_col) nxt_w = ld_cfg ? self_reg : self_sh;
            else                  nxt_w = ld_cfg ? eps_reg  : eps_sh;
            nxt_last  = ld_mode ? ((ld_row == LAST) && (ld_col == LAST)) : (ld_col == LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) x_mem[i] <= '0;
            self_reg  <= SELF_INIT;
            eps_reg   <= EPS_INIT;
            self_sh   <= SELF_INIT;
            eps_sh    <= EPS_INIT;
            mode_q    <= 1'b0;
            rd_err    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_w     <= '0;
            out_x     <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            if (x_wr_en && ({1'b0, x_wr_addr} < NUM)) x_mem[x_wr_addr] <= x_wr_data;
            if (cfg_wr_en) begin
                if (cfg_sel) self_reg <= cfg_wr_data;
                else         eps_reg  <= cfg_wr_data;
            end
            if (start_ok) begin
                self_sh <= self_reg;
                eps_sh  <= eps_reg;
                mode_q  <= rd_mode;
            end
            rd_err    <= nxt_err;
            out_valid <= nxt_valid;
            out_last  <= nxt_last;
            out_w     <= nxt_w;
            out_x     <= nxt_x;
            out_row   <= nxt_row;
            out_col   <= nxt_col;
        end
    end

endmodule
